// File: rtl/aoi21_pkg.sv
// AOI21 shared definitions: gate function, combination index type.
// Used by aoi21_bit and aoi21_x1_cell.
package aoi21_pkg;

  localparam int COMBO_W    = 3;
  localparam int NUM_COMBOS = 8;

  typedef logic [COMBO_W-1:0] combo_t;

  function automatic logic aoi21_f(
    input logic a,
    input logic b1,
    input logic b2
  );
    return ~(a | (b1 & b2));
  endfunction

endpackage

// File: rtl/aoi21_bit.sv
// Single-lane AOI21 gate: zn_o = ~(a_i | (b1_i & b2_i)).
// Ports: a_i, b1_i, b2_i in; zn_o out. Purely combinational.
module aoi21_bit
  import aoi21_pkg::*;
(
  input  logic a_i,
  input  logic b1_i,
  input  logic b2_i,
  output logic zn_o
);

  assign zn_o = aoi21_f(a_i, b1_i, b2_i);

endmodule

// File: rtl/aoi21_x1_cell.sv
// AOI21 cell wrapper: WIDTH gate lanes plus registered ZN, lane-0
// toggle counter and optional lane-0 input coverage.
// Ports: clk, rst (async high), A/B1/B2 -> ZN (comb), in_vld strobe,
// zn_q/zn_q_vld sample, tgl_cnt, cov_mask/cov_full.
// Macro AOI21_X1_CELL_COVER_EN enables the coverage flops.
module aoi21_x1_cell
  import aoi21_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] ZN,
  input  logic             in_vld,
  output logic [WIDTH-1:0] zn_q,
  output logic             zn_q_vld,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic [7:0]       cov_mask,
  output logic             cov_full
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    aoi21_bit u_bit (
      .a_i  (A[g]),
      .b1_i (B1[g]),
      .b2_i (B2[g]),
      .zn_o (ZN[g])
    );
  end

  logic [WIDTH-1:0] smp_q, smp_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shd_q, shd_d;

  always_comb begin
    smp_d = smp_q;
    vld_d = 1'b0;
    cnt_d = cnt_q;
    shd_d = shd_q;
    if (in_vld) begin
      smp_d = ZN;
      vld_d = 1'b1;
      shd_d = ZN[0];
      // saturate rather than wrap
      if ((ZN[0] != shd_q) && (cnt_q != '1))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q <= '1;
      vld_q <= 1'b0;
      cnt_q <= '0;
      shd_q <= 1'b1;
    end else begin
      smp_q <= smp_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      shd_q <= shd_d;
    end
  end

  assign zn_q     = smp_q;
  assign zn_q_vld = vld_q;
  assign tgl_cnt  = cnt_q;

`ifdef AOI21_X1_CELL_COVER_EN
  logic [NUM_COMBOS-1:0] cov_q, cov_d;
  combo_t                idx;

  assign idx = {A[0], B1[0], B2[0]};

  always_comb begin
    cov_d = cov_q;
    if (in_vld)
      cov_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cov_q <= '0;
    else     cov_q <= cov_d;
  end

  assign cov_mask = cov_q;
  assign cov_full = &cov_q;
`else
  assign cov_mask = 8'h00;
  assign cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_aoi21_x1_cell.sv
// Self-checking bench for aoi21_x1_cell: directed steps plus random
// stimulus against a truth-table reference model.
module tb_aoi21_x1_cell;

  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b1, b2;
  logic          vld;
  logic [W-1:0]  zn, znq;
  logic          znqv;
  logic [CW-1:0] cnt;
  logic [7:0]    cov;
  logic          covf;
  logic [W-1:0]  zn2, znq2;
  logic          znqv2;
  logic [1:0]    cnt2;
  logic [7:0]    cov2;
  logic          covf2;

  always #5 clk = ~clk;

  aoi21_x1_cell #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .A(a), .B1(b1), .B2(b2),
    .ZN(zn), .in_vld(vld), .zn_q(znq), .zn_q_vld(znqv),
    .tgl_cnt(cnt), .cov_mask(cov), .cov_full(covf)
  );

  aoi21_x1_cell #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A(a), .B1(b1), .B2(b2),
    .ZN(zn2), .in_vld(vld), .zn_q(znq2), .zn_q_vld(znqv2),
    .tgl_cnt(cnt2), .cov_mask(cov2), .cov_full(covf2)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]   tt;
  logic [W-1:0] m_zq;
  logic         m_v;
  int           m_cnt;
  int           m_cnt2;
  logic         m_shd;
  logic [7:0]   m_cov;

  function automatic logic [W-1:0] ref_zn(
    input logic [W-1:0] ia, input logic [W-1:0] ib1,
    input logic [W-1:0] ib2, input logic [7:0] t
  );
    logic [W-1:0] r;
    for (int i = 0; i < W; i++)
      r[i] = t[{ia[i], ib1[i], ib2[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_zq   = '1;
    m_v    = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
    m_shd  = 1'b1;
    m_cov  = 8'h00;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ec;
`ifdef AOI21_X1_CELL_COVER_EN
    ec = m_cov;
`else
    ec = 8'h00;
`endif
    chk({tag, ".zn"},   32'(zn),   32'(ref_zn(a, b1, b2, tt)));
    chk({tag, ".znq"},  32'(znq),  32'(m_zq));
    chk({tag, ".vld"},  32'(znqv), 32'(m_v));
    chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    chk({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt2));
    chk({tag, ".cov"},  32'(cov),  32'(ec));
    chk({tag, ".covf"}, 32'(covf), 32'(ec == 8'hFF));
  endtask

  // apply inputs, clock once, update model, check
  task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib1,
                      input logic [W-1:0] ib2, input logic iv,
                      input string tag);
    logic [W-1:0] z;
    a = ia; b1 = ib1; b2 = ib2; vld = iv;
    z = ref_zn(ia, ib1, ib2, tt);
    @(posedge clk);
    #1;
    if (iv) begin
      m_zq = z;
      m_v  = 1'b1;
      if (z[0] != m_shd) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_shd = z[0];
      m_cov[{ia[0], ib1[0], ib2[0]}] = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    tt = 8'h07;
    rst = 1'b1; a = '0; b1 = '0; b2 = '0; vld = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    chk("reset.zn1", 32'(zn[0]), 32'd1);

    // walk lane-0 combos while reset is held
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = 3'(c);
      a = {W{cc[2]}}; b1 = {W{cc[1]}}; b2 = {W{cc[0]}};
      #10;
      chk($sformatf("walk%0d", c), 32'(zn[0]), 32'(c < 3));
    end
    a = '0; b1 = '0; b2 = '0;
    @(negedge clk);
    rst = 1'b0;

    step('1, '0, '0, 1'b1, "capA1");
    chk("capA1.znq0", 32'(znq), 32'd0);
    step('1, '0, '0, 1'b0, "hold");
    chk("hold.vld0", 32'(znqv), 32'd0);

    pulse_reset();
    for (int i = 0; i < 6; i++)
      step(i[0] ? '0 : '1, '0, '0, 1'b1, "alt");
    chk("alt.cnt6", 32'(cnt), 32'd6);
    chk("alt.sat3", 32'(cnt2), 32'd3);

    a = 4'b0101; b1 = 4'b0011; b2 = 4'b0110;
    #1;
    chk("w4.zn", 32'(zn), 32'h8);

    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = 3'(c);
      step({W{cc[2]}}, {W{cc[1]}}, {W{cc[0]}}, 1'b1, "cov");
    end

    for (int i = 0; i < 200; i++)
      step(W'($urandom), W'($urandom), W'($urandom),
           1'($urandom), "rnd");

    // async reset mid-cycle
    step('0, '1, '1, 1'b1, "pre");
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      step(W'($urandom), W'($urandom), W'($urandom),
           1'($urandom), "post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
